// File: rtl/sm_data_bus_pkg.sv
// Shared constants and address-region decode for the core data-side bus.
package sm_data_bus_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] ADDR_GPIO_OUT = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_GPIO_IN  = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_TMR_CNT  = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_TMR_CMP  = 32'hFFFF_000C;
  localparam logic [31:0] ADDR_TMR_CTRL = 32'hFFFF_0010;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_AUTOCLR = 1;
  localparam int unsigned CTRL_MATCH   = 8;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_GPIO_OUT,
    REG_GPIO_IN,
    REG_TMR_CNT,
    REG_TMR_CMP,
    REG_TMR_CTRL,
    REG_NONE
  } region_e;

  // RAM only when every bit above the word index is zero, so aliases fall to REG_NONE.
  function automatic region_e decode_region(input logic [31:0] addr, input int unsigned ram_aw);
    logic [31:0] word_addr;
    region_e     region;
    word_addr = {addr[31:2], 2'b00};
    region    = REG_NONE;
    if ((word_addr >> (ram_aw + 32'd2)) == 32'd0) begin
      region = REG_RAM;
    end else begin
      case (word_addr)
        ADDR_GPIO_OUT: region = REG_GPIO_OUT;
        ADDR_GPIO_IN:  region = REG_GPIO_IN;
        ADDR_TMR_CNT:  region = REG_TMR_CNT;
        ADDR_TMR_CMP:  region = REG_TMR_CMP;
        ADDR_TMR_CTRL: region = REG_TMR_CTRL;
        default:       region = REG_NONE;
      endcase
    end
    return region;
  endfunction

endpackage

// File: rtl/sm_data_bus_if.sv
// Core data-memory port: address/strobe/data from the core, combinational load data back.
interface sm_data_bus_if;
  logic [31:0] dataMemory_address;
  logic        dataMemory_writeEnable;
  logic [31:0] dataMemory_writeData;
  logic [31:0] dataMemory_readData;

  modport master (
    output dataMemory_address,
    output dataMemory_writeEnable,
    output dataMemory_writeData,
    input  dataMemory_readData
  );

  modport slave (
    input  dataMemory_address,
    input  dataMemory_writeEnable,
    input  dataMemory_writeData,
    output dataMemory_readData
  );
endinterface

// File: rtl/sm_timer.sv
// 32-bit compare timer: count/compare/ctrl registers with sticky W1C match flag.
module sm_timer
  import sm_data_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_p,
  input  logic        cnt_we_i,
  input  logic        cmp_we_i,
  input  logic        ctrl_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] cmp_o,
  output logic [31:0] ctrl_o,
  output logic        match_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        autoclr_q, autoclr_d;
  logic        match_q, match_d;
  logic        hit;

  // Compare on the pre-write count; a CNT write overrides increment/auto-clear,
  // and a fresh match beats a same-cycle W1C.
  always_comb begin
    hit       = en_q && (count_q == cmp_q);
    count_d   = count_q;
    cmp_d     = cmp_q;
    en_d      = en_q;
    autoclr_d = autoclr_q;
    match_d   = match_q;
    if (en_q) begin
      count_d = (hit && autoclr_q) ? 32'd0 : count_q + 32'd1;
    end
    if (cnt_we_i) begin
      count_d = wdata_i;
    end
    if (cmp_we_i) begin
      cmp_d = wdata_i;
    end
    if (ctrl_we_i) begin
      en_d      = wdata_i[CTRL_EN];
      autoclr_d = wdata_i[CTRL_AUTOCLR];
      if (wdata_i[CTRL_MATCH]) begin
        match_d = 1'b0;
      end
    end
    if (hit) begin
      match_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      count_q   <= 32'd0;
      cmp_q     <= 32'd0;
      en_q      <= 1'b0;
      autoclr_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      autoclr_q <= autoclr_d;
      match_q   <= match_d;
    end
  end

  always_comb begin
    ctrl_o               = 32'd0;
    ctrl_o[CTRL_EN]      = en_q;
    ctrl_o[CTRL_AUTOCLR] = autoclr_q;
    ctrl_o[CTRL_MATCH]   = match_q;
  end

  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign match_o = match_q;

endmodule

// File: rtl/sm_data_bus.sv
// Data-side bus of the single-cycle core: word RAM plus GPIO/timer peripheral window.
module sm_data_bus
  import sm_data_bus_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned GPIO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_p,
  sm_data_bus_if.slave          bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_match
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  region_e              region;
  logic [AW-1:0]        ram_idx;
  logic                 we;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic [31:0]          mem_q [RAM_WORDS];
  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;
  logic [31:0]          tmr_count, tmr_cmp, tmr_ctrl;
  logic                 tmr_match;

  assign region  = decode_region(bus.dataMemory_address, AW);
  assign ram_idx = bus.dataMemory_address[AW+1:2];
  assign we      = bus.dataMemory_writeEnable;
  assign wdata   = bus.dataMemory_writeData;

  // RAM is not reset; a store during reset is dropped.
  always_ff @(posedge clk) begin
    if (we && !rst_p && (region == REG_RAM)) begin
      mem_q[ram_idx] <= wdata;
    end
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (we && (region == REG_GPIO_OUT)) begin
      gpio_out_d = wdata[GPIO_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
    end
  end

  sm_timer u_timer (
    .clk       (clk),
    .rst_p     (rst_p),
    .cnt_we_i  (we && (region == REG_TMR_CNT)),
    .cmp_we_i  (we && (region == REG_TMR_CMP)),
    .ctrl_we_i (we && (region == REG_TMR_CTRL)),
    .wdata_i   (wdata),
    .count_o   (tmr_count),
    .cmp_o     (tmr_cmp),
    .ctrl_o    (tmr_ctrl),
    .match_o   (tmr_match)
  );

  // Zero-latency load mux; unmapped addresses read 0.
  always_comb begin
    rdata = 32'd0;
    case (region)
      REG_RAM:      rdata = mem_q[ram_idx];
      REG_GPIO_OUT: rdata = 32'(gpio_out_q);
      REG_GPIO_IN:  rdata = 32'(sync2_q);
      REG_TMR_CNT:  rdata = tmr_count;
      REG_TMR_CMP:  rdata = tmr_cmp;
      REG_TMR_CTRL: rdata = tmr_ctrl;
      default:      rdata = 32'd0;
    endcase
  end

  assign bus.dataMemory_readData = rdata;
  assign gpio_out                = gpio_out_q;
  assign timer_match             = tmr_match;

endmodule
